divider_32bit: RTL and testbench
================================

# divider_32bit

Multi-cycle 32-bit integer divider for the datapath ALU, built around a 32-bit subtract step. It performs one restoring-division iteration per clock, produces a quotient and a remainder, and reports completion with a start/busy/done handshake. The control unit stalls on `busy` and captures results on `done`.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is supported and verified.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request a division; sampled only in IDLE.
- `dividend` input 32: numerator; captured on the accepted `start` edge.
- `divisor` input 32: denominator; captured on the accepted `start` edge.
- `busy` output 1: high from the accepted start through the DONE cycle.
- `done` output 1: one-cycle pulse; results are valid in that cycle.
- `quotient` output 32: result quotient; holds until the next accepted start.
- `remainder` output 32: result remainder; holds until the next accepted start.
- `div_by_zero` output 1: set with `done` when the captured divisor is 0; holds with the results.

## Operation

States and transitions:
- IDLE: `busy=0`, `done=0`.
  - `start=1` with divisor≠0 → RUN: load operands, iteration count=0, partial remainder=0.
  - `start=1` with divisor=0 → DONE directly.
- RUN: each edge performs one restoring step:
  - shift {rem, dvd} left by 1;
  - compute trial = rem − divisor (33-bit, using the carry as not-borrow);
  - if no borrow, rem = trial and the quotient LSB = 1, else the quotient LSB = 0;
  - count increments; after the 32nd step → DONE.
- DONE: `done=1` and `busy=1` for exactly one cycle → IDLE. `quotient`, `remainder` and `div_by_zero` are registered on entry to DONE.

Result rules:
- Unsigned (default): quotient = floor(dividend/divisor); remainder = dividend − quotient·divisor.
- Divide by zero: `quotient=32'hFFFF_FFFF`, `remainder=dividend`, `div_by_zero=1`.
- Otherwise `div_by_zero=0`.

Boundary conditions:
- `start` while `busy=1` is ignored; the in-flight operation is unaffected.
- `start` held high in the DONE cycle is ignored. It is accepted on the following edge, once the block is back in IDLE.
- `rst_n` low at any time, including mid-RUN: immediate return to IDLE; all outputs go to 0; the in-flight result is discarded.
- Operand inputs may change freely after the accepting edge.

## Timing

- Reset values: `busy=0`, `done=0`, `quotient=0`, `remainder=0`, `div_by_zero=0`.
- Normal latency:
  - `start` is sampled at edge E0;
  - `busy` is high after E0;
  - the 32 iterations occur at E1..E32; E32 enters DONE;
  - `done` is high in the cycle after E32 and low after E33.
- Divide-by-zero latency: `done` is high in the cycle after E0.
- Minimum spacing between accepted starts is 34 edges; with a zero divisor it is 2 edges.
- No combinational path exists from any input to any output.

## Configuration

- `DIVIDER_SIGNED_EN` defined: two's-complement signed division.
  - Magnitudes are divided; the quotient sign is sign(dividend) XOR sign(divisor); the remainder takes the sign of the dividend (truncating division).
  - Sign correction is applied on entry to DONE, so latency is unchanged.
  - `0x8000_0000 / 0xFFFF_FFFF` gives quotient `0x8000_0000`, remainder 0.
  - Divide by zero gives quotient `0xFFFF_FFFF`, remainder = dividend.
- Not defined: unsigned only, with no sign logic synthesized.

## Test plan

- Reset then `start` with 100 / 7 → `busy` for 33 cycles; `done` one cycle after E32 with quotient 14, remainder 2, `div_by_zero=0`; results hold afterward.
- `0xFFFF_FFFF / 1` and `5 / 9` → quotient `0xFFFF_FFFF`, remainder 0; then quotient 0, remainder 5.
- `1234 / 0` → `done` the cycle after E0 with quotient `0xFFFF_FFFF`, remainder 1234, `div_by_zero=1`.
- `start` pulsed again mid-RUN with different operands → ignored; the original result is delivered at the original time. Then `rst_n` low at iteration 10 of a new operation → all outputs 0 immediately, no `done`.
- `start` held high continuously with 50 / 5 → back-to-back operations 34 edges apart, each giving quotient 10, remainder 0.
- With `DIVIDER_SIGNED_EN`:
  - −7 / 2 → quotient −3, remainder −1;
  - 7 / −2 → quotient −3, remainder 1;
  - `0x8000_0000 / 0xFFFF_FFFF` → quotient `0x8000_0000`, remainder 0.

Source files
------------

// File: rtl/divider_32bit.sv
// divider_32bit: multi-cycle restoring divider, one step per clock; DIVIDER_SIGNED_EN selects signed mode
module divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] dvd, rem, dsr, rem_n, dvd_n, q_fix, r_fix, a_mag, b_mag;
  logic [WIDTH:0] sh;
  logic [WIDTH+1:0] diff;
  logic [5:0] cnt;
  logic nb;
  always_comb begin
    sh = {rem, dvd[WIDTH-1]};
    diff = {1'b0, sh} - {2'b0, dsr};
    nb = ~diff[WIDTH+1];
    rem_n = nb ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    dvd_n = {dvd[WIDTH-2:0], nb};
  end
`ifdef DIVIDER_SIGNED_EN
  logic qneg, rneg;
  always_comb begin
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1] ? -divisor : divisor;
    q_fix = qneg ? -dvd_n : dvd_n;
    r_fix = rneg ? -rem_n : rem_n;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (state == IDLE && start) begin
      qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg <= dividend[WIDTH-1];
    end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fix = dvd_n;
    r_fix = rem_n;
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      dvd <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
    end else
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            cnt <= '0;
            rem <= '0;
            dvd <= a_mag;
            dsr <= b_mag;
            if (divisor == '0) begin
              state <= DONE;
              done <= 1'b1;
              quotient <= '1;
              remainder <= dividend;
              div_by_zero <= 1'b1;
            end else
              state <= RUN;
          end
        end
        RUN: begin
          rem <= rem_n;
          dvd <= dvd_n;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1)) begin
            state <= DONE;
            done <= 1'b1;
            quotient <= q_fix;
            remainder <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_divider_32bit.sv
// tb_divider_32bit: directed-vector bench for divider_32bit
module tb_divider_32bit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  divider_32bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int glitch);
    int bad = 0;
    dividend = a;
    divisor = b;
    start = 1'b1;
    step();
    start = 1'b0;
    dividend = 32'h5A5A_5A5A;
    divisor = 32'h0000_0003;
    if (b != 0)
      for (int i = 1; i <= 32; i++) begin
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        start = (i == glitch);
        step();
        start = 1'b0;
      end
    chk({tag, "_wait"}, bad, 0);
    chk({tag, "_done"}, {busy, done}, 2'b11);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, b == 0);
    step();
    chk({tag, "_end"}, {busy, done}, 2'b00);
    chk({tag, "_hold"}, {quotient, remainder}, {eq, er});
  endtask
  initial begin
    int bad;
    #12;
    chk("rst_ctl", {busy, done, div_by_zero}, 3'b000);
    chk("rst_res", {quotient, remainder}, 64'd0);
    rst_n = 1'b1;
    step();
    run_op("u100_7", 100, 7, 14, 2, 0);
    run_op("umax_1", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0);
    run_op("u5_9", 5, 9, 0, 5, 0);
    run_op("dz1234", 1234, 0, 32'hFFFF_FFFF, 1234, 0);
    run_op("glitch", 100, 7, 14, 2, 10);
`ifdef DIVIDER_SIGNED_EN
    run_op("sm7_2", -32'sd7, 2, -32'sd3, -32'sd1, 0);
    run_op("s7_m2", 7, -32'sd2, -32'sd3, 1, 0);
    run_op("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run_op("sdz", -32'sd5, 0, 32'hFFFF_FFFF, -32'sd5, 0);
`else
    run_op("umin_max", 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0);
`endif
    dividend = 1000;
    divisor = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {busy, done, div_by_zero}, 3'b000);
    chk("mid_rst_res", {quotient, remainder}, 64'd0);
    step();
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      step();
    end
    chk("post_rst_idle", bad, 0);
    dividend = 50;
    divisor = 5;
    start = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      repeat (32) step();
      chk("b2b_done", {busy, done}, 2'b11);
      chk("b2b_res", {quotient, remainder}, {32'd10, 32'd0});
      step();
      chk("b2b_gap", {busy, done}, 2'b00);
      if (k == 2) start = 1'b0;
      step();
      chk("b2b_next", busy, k != 2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
